store_narrow_unit: RTL
======================

// Module: store_narrow_unit
// PURPOSE
//  Store-side counterpart of the load/immediate widening path. Accepts a 32-bit
//  register value with a store size (byte/half/word) and narrows it into a
//  word-organised data memory. Sub-word stores use a read-modify-write sequence.
//  Sits between the EX/MEM stage and the data memory.
// PARAMETERS
//  ADDR_W      32  byte-address width; memory is addressed word-aligned
//  BIG_ENDIAN  0   0: lane = addr[1:0] (byte0 = bits 7:0); 1: lane = 3-addr[1:0]
// PORTS
//  Clk          in   1       clock, rising edge
//  Rst          in   1       asynchronous, active-high reset
//  req_valid    in   1       store request present
//  req_ready    out  1       unit can accept a request (IDLE only)
//  req_addr     in   ADDR_W  byte address
//  req_data     in   32      register value; low 8/16/32 bits are stored
//  req_size     in   2       00 byte, 01 half, 10 word, 11 illegal
//  mem_addr     out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
//  mem_rd_en    out  1       read strobe; mem_rd_data is valid the following cycle
//  mem_rd_data  in   32      read data
//  mem_wr_en    out  1       write strobe, one cycle per store
//  mem_wr_data  out  32      merged write word
//  done         out  1       1-cycle pulse: store committed
//  err          out  1       1-cycle pulse: misaligned/illegal, nothing written
// BEHAVIOUR
//  - States: IDLE, READ, WAIT, WRITE, ERR. Request, addr, data and size are
//    captured on the handshake (req_valid & req_ready).
//  - IDLE: req_ready=1. On handshake:
//      size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
//      word -> WRITE. byte/half -> READ.
//  - READ: mem_rd_en=1, mem_addr = captured word address -> WAIT.
//  - WAIT: capture mem_rd_data and merge the new byte/half into its lane(s) -> WRITE.
//  - WRITE: mem_wr_en=1, mem_wr_data = merged word (word store: req_data
//    unmodified), done=1 -> IDLE.
//  - ERR: err=1, no memory strobe -> IDLE.
//  - Latency from handshake to done/err: word 1 cycle, byte/half 3 cycles,
//    error 1 cycle. Throughput: one request in flight; req_ready=0 outside IDLE.
//  - Half lane: addr[1]=0 -> bytes 1:0, addr[1]=1 -> bytes 3:2 (mirrored when
//    BIG_ENDIAN=1). Unselected lanes keep the read-back value bit-exactly.
//  - mem_addr is held stable from READ through WRITE. Strobes are zero in all
//    other states.
//  - Reset (async, any state): state=IDLE, req_ready=1. mem_rd_en, mem_wr_en,
//    done, err, mem_addr, mem_wr_data and all capture registers are 0. A store
//    interrupted mid-sequence is dropped and no write is issued.
//  - req_valid while busy is ignored. The requester must hold the request until
//    req_ready.
// CONFIGURATION
//  NARROW_OVF_CHECK_EN defined:
//    - Adds output port ovf (1 bit), pulsed together with done.
//    - ovf=1 when the stored byte/half, sign-extended back to 32 bits, differs
//      from req_data. Examples: byte 0x00000080 -> ovf=1; byte 0xFFFFFF80 -> ovf=0.
//    - Word stores never flag. Data is still written.
//  Not defined: port ovf is absent and no check logic is built.
// TESTING
//  1. Word: addr 0x10, data 0xDEADBEEF, size 10 -> 1 cycle later wr_en=1,
//     mem_addr 0x10, wr_data 0xDEADBEEF, done=1, rd_en never asserted.
//  2. Byte, BIG_ENDIAN=0: mem[0x20]=0x11223344; addr 0x22, data 0x000000AB ->
//     rd_en at +1, wr_data 0x11AB3344 with done at +3.
//  3. Half: mem[0x20]=0x11223344; addr 0x22, data 0xFFFFCAFE ->
//     wr_data 0xCAFE3344. Same stimulus with BIG_ENDIAN=1 -> 0x1122CAFE.
//  4. Misaligned: half at 0x21, word at 0x22, size 11 -> each gives err=1 at +1,
//     no rd_en/wr_en, req_ready=1 at +2.
//  5. Reset mid-op: assert Rst during WAIT of a byte store -> wr_en never rises,
//     outputs 0 immediately, next store accepted after Rst drops.
//  6. NARROW_OVF_CHECK_EN: byte 0x00000080 -> ovf=1; byte 0xFFFFFF80 -> ovf=0;
//     half 0x00017FFF -> ovf=1; word -> ovf=0.

Source files
------------

// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
//
// Purpose:
//   Store-side narrowing path between EX/MEM and a word-organised data memory.
//   Takes a 32-bit register value and a store size (byte/half/word), and
//   commits it to memory. Word stores are written directly. Byte and half
//   stores use a read-modify-write: read the containing word, splice the new
//   byte/half into its lane(s), and write the merged word back. Only one
//   request is in flight at a time.
//
// Configuration:
//   NARROW_OVF_CHECK_EN - when defined, adds o_ovf. It pulses with o_done when
//                         the stored byte/half, sign-extended back to 32 bits,
//                         differs from the register value. Word stores never
//                         flag, and the data is written either way.
//
// Parameters:
//   ADDR_W     - byte-address width. Memory is addressed word-aligned.
//   BIG_ENDIAN - 0: byte lane = addr[1:0]; 1: byte lane = 3 - addr[1:0].
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_req_valid    store request present
//   o_req_ready    unit can accept a request (IDLE only)
//   i_req_addr     byte address
//   i_req_data     register value; the low 8/16/32 bits are stored
//   i_req_size     00 byte, 01 half, 10 word, 11 illegal
//   o_mem_addr     word address {addr[ADDR_W-1:2], 2'b00}
//   o_mem_rd_en    read strobe; i_mem_rd_data is valid the following cycle
//   i_mem_rd_data  read data
//   o_mem_wr_en    write strobe, one cycle per store
//   o_mem_wr_data  merged write word
//   o_done         1-cycle pulse: store committed
//   o_err          1-cycle pulse: misaligned/illegal request, nothing written
//   o_ovf          (NARROW_OVF_CHECK_EN only) narrowing lost information
// -----------------------------------------------------------------------------
module store_narrow_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_data,
  input  logic [1:0]        i_req_size,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd_en,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_mem_wr_en,
  output logic [31:0]       o_mem_wr_data,
  output logic              o_done,
  output logic              o_err
`ifdef NARROW_OVF_CHECK_EN
  ,
  output logic              o_ovf
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_size;
  logic [31:0]       r_merged;

  logic              w_hs;
  logic              w_bad;
  logic [1:0]        w_lane;
  logic              w_hsel;
  logic [31:0]       w_merged;

  // ---------------------------------------------------------------------------
  // Request acceptance and alignment check
  // ---------------------------------------------------------------------------
  assign w_hs = i_req_valid & o_req_ready;

  // Bytes can never be misaligned. Halves need addr[0]=0, words need
  // addr[1:0]=0, and size 11 is always rejected.
  assign w_bad = (i_req_size == SZ_ILL) ||
                 ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                 ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));

  // ---------------------------------------------------------------------------
  // Lane selection. For two bits, 3 - x is simply ~x.
  // The half-lane select mirrors the same way: addr[1]=0 picks the upper
  // half in big-endian mode.
  // ---------------------------------------------------------------------------
  assign w_lane = BIG_ENDIAN ? ~r_addr[1:0] : r_addr[1:0];
  assign w_hsel = BIG_ENDIAN ? ~r_addr[1]   : r_addr[1];

  // Splice the captured byte/half into the read-back word. Lanes that are
  // not selected pass through bit-exactly.
  always_comb begin
    w_merged = i_mem_rd_data;
    if (r_size == SZ_BYTE) begin
      case (w_lane)
        2'd0:    w_merged[7:0]   = r_data[7:0];
        2'd1:    w_merged[15:8]  = r_data[7:0];
        2'd2:    w_merged[23:16] = r_data[7:0];
        default: w_merged[31:24] = r_data[7:0];
      endcase
    end else begin
      if (w_hsel) w_merged[31:16] = r_data[15:0];
      else        w_merged[15:0]  = r_data[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            if (w_bad)                    r_state <= S_ERR;
            else if (i_req_size == SZ_WORD) r_state <= S_WRITE;
            else                          r_state <= S_READ;
          end
        end
        S_READ:  r_state <= S_WAIT;
        S_WAIT:  r_state <= S_WRITE;
        S_WRITE: r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Capture registers. Request fields are latched on every handshake,
  // including rejected ones, so they stay constant for the whole sequence.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_size <= '0;
    end else if (w_hs) begin
      r_addr <= i_req_addr;
      r_data <= i_req_data;
      r_size <= i_req_size;
    end
  end

  // The read-back word arrives in WAIT, one cycle after the READ strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 r_merged <= '0;
    else if (r_state == S_WAIT) r_merged <= w_merged;
  end

  // ---------------------------------------------------------------------------
  // Outputs. Strobes and pulses decode directly from state, so an async
  // reset clears them immediately and a dropped store can never write.
  // ---------------------------------------------------------------------------
  assign o_req_ready   = (r_state == S_IDLE);
  assign o_mem_rd_en   = (r_state == S_READ);
  assign o_mem_wr_en   = (r_state == S_WRITE);
  assign o_done        = (r_state == S_WRITE);
  assign o_err         = (r_state == S_ERR);
  assign o_mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
  // A word store bypasses the merge and writes the captured value unmodified.
  assign o_mem_wr_data = (r_size == SZ_WORD) ? r_data : r_merged;

`ifdef NARROW_OVF_CHECK_EN
  // ---------------------------------------------------------------------------
  // Narrowing overflow: the value does not survive a sign-extending reload.
  // This is evaluated on the live request and held until the commit pulse.
  // ---------------------------------------------------------------------------
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (i_req_size)
      SZ_BYTE: w_ovf = ({{24{i_req_data[7]}},  i_req_data[7:0]}  != i_req_data);
      SZ_HALF: w_ovf = ({{16{i_req_data[15]}}, i_req_data[15:0]} != i_req_data);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_ovf <= 1'b0;
    else if (w_hs) r_ovf <= w_ovf;
  end

  assign o_ovf = o_done & r_ovf;
`endif

endmodule
